// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the fetch FSM state enum, the default reset PC, the queue depth
// constant and the instruction queue entry layout {pc, instr}.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          FETCH_QDEPTH     = 2;

  // RUN  : no request outstanding, free to issue
  // WAIT : one request outstanding, its response will be queued
  // DROP : one request outstanding, its response will be thrown away
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries for decode.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   flush          - clears count and both pointers on the next edge
//   push           - write push_entry at the tail
//   push_entry     - entry to write
//   pop            - drop the head entry
//   head_entry     - current head entry (valid when count != 0)
//   count          - number of entries held
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_QDEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  output fetch_entry_t       head_entry,
  output logic [CNT_W-1:0]   count
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

  fetch_entry_t       mem_q [DEPTH];
  fetch_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also behave.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign do_push    = push && (count_q != FULL_COUNT);
  assign do_pop     = pop && (count_q != '0);
  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

  // Next-state for storage, pointers and occupancy. A flush wins over
  // any push or pop in the same cycle; stale storage is left in place
  // because the count alone decides what is visible.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Register update with synchronous reset back to an empty queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding memory request
// FSM and a small instruction queue toward decode.
// Ports:
//   clk, reset                     - rising-edge clock, sync active-high reset
//   next_PC, PCWrite, redirect     - PC-select value, hazard enable, taken branch
//   current_PC                     - PC register, fed back to the PC mux
//   imem_req_valid/addr/ready      - fetch request handshake (addr = current_PC)
//   imem_resp_valid/data           - fetch response
//   id_valid/id_pc/id_instr        - queue head toward decode
//   id_ready                       - decode consumes the head
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = FETCH_QDEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_PC,
  input  logic        PCWrite,
  input  logic        redirect,
  output logic [31:0] current_PC,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready
);

  localparam int               CNT_W      = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QDEPTH);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic               fire;
  logic               q_push;
  logic               q_pop;
  logic [CNT_W-1:0]   q_count;
  fetch_entry_t       q_head;
  fetch_entry_t       q_push_entry;

  assign current_PC    = pc_q;
  assign imem_req_addr = pc_q;
  assign id_valid      = (q_count != '0) && !reset;
  assign id_pc         = q_head.pc;
  assign id_instr      = q_head.instr;
  assign q_pop         = id_valid && id_ready && !redirect;
  assign q_push_entry  = '{pc: req_pc_q, instr: imem_resp_data};

  // Request issue and outstanding-transaction tracking. A request only
  // goes out with nothing outstanding and room left in the queue, so a
  // push can never land on a full queue. A redirect while waiting turns
  // the in-flight response into one that must be dropped.
  always_comb begin
    imem_req_valid = (state_q == RUN) && (q_count < FULL_COUNT) && !redirect && !reset;
    fire           = imem_req_valid && imem_req_ready;
    state_d        = state_q;
    q_push         = 1'b0;
    case (state_q)
      RUN: begin
        if (fire) state_d = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          q_push  = !redirect;
          state_d = RUN;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_resp_valid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // PC update: a redirect always wins; otherwise the PC only advances
  // when a request fires and the hazard unit allows it, so a stalled
  // fire re-fetches the same address. The issued address is remembered
  // so it can be paired with its response.
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect) begin
      pc_d = next_PC;
    end else if (fire && PCWrite) begin
      pc_d = next_PC;
    end
    if (fire) begin
      req_pc_d = pc_q;
    end
  end

  // State registers; reset takes priority over everything, including a
  // redirect, and abandons any outstanding transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (q_pop),
    .head_entry (q_head),
    .count      (q_count)
  );

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Testbench for pc_fetch_stage: a table of per-cycle vectors for the basic
// fetch stream, hand-written sequences for the stall, redirect, PCWrite and
// reset corner cases, then randomized traffic against a transaction-level
// reference model.
module tb_pc_fetch_stage;
  import fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] next_PC;
  logic        PCWrite;
  logic        redirect;
  logic [31:0] current_PC;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;

  int compare_count  = 0;
  int mismatch_count = 0;

  localparam logic [31:0] I0 = 32'h1111_0013;
  localparam logic [31:0] I1 = 32'h2222_0093;
  localparam logic [31:0] I2 = 32'h3333_0113;

  typedef struct {
    logic        rst;
    logic        rdir;
    logic        pcw;
    logic [31:0] npc;
    logic        rdy;
    logic        rvld;
    logic [31:0] rdata;
    logic        idr;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_idv;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [8];

  // Reference model: PC, whether a response is owed and whether it will
  // be kept or thrown away, and the queue contents toward decode.
  logic [31:0]  m_pc;
  logic [31:0]  m_req_pc;
  bit           m_busy;
  bit           m_discard;
  fetch_entry_t m_q [$];

  pc_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .next_PC         (next_PC),
    .PCWrite         (PCWrite),
    .redirect        (redirect),
    .current_PC      (current_PC),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_instr        (id_instr),
    .id_ready        (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs after the falling edge, settle, then return
  // so the caller can sample away from the rising edge.
  task automatic applyStimulus(input logic rst, input logic rdir, input logic pcw,
                               input logic [31:0] npc, input logic rdy, input logic rvld,
                               input logic [31:0] rdata, input logic idr);
    @(negedge clk);
    reset           = rst;
    redirect        = rdir;
    PCWrite         = pcw;
    next_PC         = npc;
    imem_req_ready  = rdy;
    imem_resp_valid = rvld;
    imem_resp_data  = rdata;
    id_ready        = idr;
    #1;
  endtask

  task automatic checkWord(input string name, input logic [31:0] got, input logic [31:0] exp);
    compare_count++;
    if (got !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_rv, input logic [31:0] exp_addr,
                             input logic exp_idv, input logic [31:0] exp_pc,
                             input logic [31:0] exp_instr);
    checkWord({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, exp_rv});
    checkWord({tag, ".req_addr"}, imem_req_addr, exp_addr);
    checkWord({tag, ".current_PC"}, current_PC, exp_addr);
    checkWord({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, exp_idv});
    if (exp_idv) begin
      checkWord({tag, ".id_pc"}, id_pc, exp_pc);
      checkWord({tag, ".id_instr"}, id_instr, exp_instr);
    end
  endtask

  task automatic doReset(input string tag);
    applyStimulus(1, 0, 1, 32'h0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 1, 32'h0, 0, 0, 32'h0, 0);
    checkOutput(tag, 0, DEFAULT_RESET_PC, 0, 0, 0);
  endtask

  // Advance the reference model by one clock using the inputs currently
  // driven; expected outputs for this cycle must be taken before calling.
  task automatic modelStep();
    bit req, fire, keep, take;
    if (reset) begin
      m_pc      = DEFAULT_RESET_PC;
      m_req_pc  = '0;
      m_busy    = 0;
      m_discard = 0;
      m_q.delete();
      return;
    end
    req  = !m_busy && !m_discard && (m_q.size() < 2) && !redirect;
    fire = req && imem_req_ready;
    keep = m_busy && imem_resp_valid && !redirect;
    take = (m_q.size() != 0) && id_ready && !redirect;
    if (redirect) begin
      m_q.delete();
    end else begin
      if (take) void'(m_q.pop_front());
      if (keep) m_q.push_back('{pc: m_req_pc, instr: imem_resp_data});
    end
    if (fire) begin
      m_busy   = 1;
      m_req_pc = m_pc;
    end else if (m_busy) begin
      if (imem_resp_valid) m_busy = 0;
      else if (redirect) begin
        m_busy    = 0;
        m_discard = 1;
      end
    end else if (m_discard && imem_resp_valid) begin
      m_discard = 0;
    end
    if (redirect) m_pc = next_PC;
    else if (fire && PCWrite) m_pc = next_PC;
  endtask

  initial begin
    reset = 1; redirect = 0; PCWrite = 1; next_PC = 0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0; id_ready = 0;

    // Plain fetch stream: ready memory, one-cycle responses, PC+4.
    vecs[0] = '{0, 0, 1, 32'h04, 1, 0, 32'h0, 1, 1, 32'h00, 0, 32'h0, 32'h0};
    vecs[1] = '{0, 0, 1, 32'h08, 1, 1, I0,    1, 0, 32'h04, 0, 32'h0, 32'h0};
    vecs[2] = '{0, 0, 1, 32'h08, 1, 0, 32'h0, 1, 1, 32'h04, 1, 32'h0, I0};
    vecs[3] = '{0, 0, 1, 32'h0C, 1, 1, I1,    1, 0, 32'h08, 0, 32'h0, 32'h0};
    vecs[4] = '{0, 0, 1, 32'h0C, 1, 0, 32'h0, 1, 1, 32'h08, 1, 32'h4, I1};
    vecs[5] = '{0, 0, 1, 32'h10, 1, 1, I2,    1, 0, 32'h0C, 0, 32'h0, 32'h0};
    vecs[6] = '{0, 0, 1, 32'h10, 0, 0, 32'h0, 1, 1, 32'h0C, 1, 32'h8, I2};
    vecs[7] = '{0, 0, 1, 32'h10, 0, 0, 32'h0, 1, 1, 32'h0C, 0, 32'h0, 32'h0};

    doReset("reset0");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rdir, vecs[i].pcw, vecs[i].npc, vecs[i].rdy,
                    vecs[i].rvld, vecs[i].rdata, vecs[i].idr);
      checkOutput($sformatf("stream[%0d]", i), vecs[i].exp_rv, vecs[i].exp_addr,
                  vecs[i].exp_idv, vecs[i].exp_pc, vecs[i].exp_instr);
    end

    // Decode stalled: queue fills, requests stop, then drains in order.
    doReset("reset1");
    applyStimulus(0, 0, 1, 32'h04, 1, 0, 32'h0, 0); checkOutput("fill0", 1, 32'h0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h08, 1, 1, I0,    0); checkOutput("fill1", 0, 32'h4, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h08, 1, 0, 32'h0, 0); checkOutput("fill2", 1, 32'h4, 1, 32'h0, I0);
    applyStimulus(0, 0, 1, 32'h0C, 1, 1, I1,    0); checkOutput("fill3", 0, 32'h8, 1, 32'h0, I0);
    applyStimulus(0, 0, 1, 32'h0C, 1, 0, 32'h0, 0); checkOutput("full", 0, 32'h8, 1, 32'h0, I0);
    applyStimulus(0, 0, 1, 32'h0C, 1, 0, 32'h0, 1); checkOutput("drain0", 0, 32'h8, 1, 32'h0, I0);
    applyStimulus(0, 0, 1, 32'h0C, 1, 0, 32'h0, 1); checkOutput("drain1", 1, 32'h8, 1, 32'h4, I1);
    applyStimulus(0, 0, 1, 32'h10, 0, 1, I2,    1); checkOutput("resume", 0, 32'hC, 0, 0, 0);

    // Redirect while waiting: the late response is dropped.
    doReset("reset2");
    applyStimulus(0, 0, 1, 32'h004, 1, 0, 32'h0, 1);        checkOutput("rdw0", 1, 32'h000, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'h100, 1, 0, 32'h0, 1);        checkOutput("rdw1", 0, 32'h004, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h104, 1, 1, 32'hDEAD_BEEF, 1); checkOutput("rdw2", 0, 32'h100, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h104, 0, 0, 32'h0, 1);        checkOutput("rdw3", 1, 32'h100, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h104, 0, 0, 32'h0, 1);        checkOutput("rdw4", 1, 32'h100, 0, 0, 0);

    // Redirect in the same cycle as the response: nothing pushed.
    doReset("reset3");
    applyStimulus(0, 0, 1, 32'h004, 1, 0, 32'h0, 1);        checkOutput("rdr0", 1, 32'h000, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'h100, 1, 1, 32'hBEEF_0001, 1); checkOutput("rdr1", 0, 32'h004, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h104, 0, 0, 32'h0, 1);        checkOutput("rdr2", 1, 32'h100, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h104, 0, 0, 32'h0, 1);        checkOutput("rdr3", 1, 32'h100, 0, 0, 0);

    // PCWrite low during fire: same address fetched and queued twice.
    doReset("reset4");
    applyStimulus(0, 0, 0, 32'h04, 1, 0, 32'h0, 0); checkOutput("hold0", 1, 32'h0, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h04, 1, 1, I0,    0); checkOutput("hold1", 0, 32'h0, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h04, 1, 0, 32'h0, 0); checkOutput("hold2", 1, 32'h0, 1, 32'h0, I0);
    applyStimulus(0, 0, 0, 32'h04, 1, 1, I1,    0); checkOutput("hold3", 0, 32'h0, 1, 32'h0, I0);
    applyStimulus(0, 0, 0, 32'h04, 1, 0, 32'h0, 1); checkOutput("hold4", 0, 32'h0, 1, 32'h0, I0);
    applyStimulus(0, 0, 0, 32'h04, 0, 0, 32'h0, 1); checkOutput("hold5", 1, 32'h0, 1, 32'h0, I1);
    applyStimulus(0, 0, 0, 32'h04, 0, 0, 32'h0, 1); checkOutput("hold6", 1, 32'h0, 0, 0, 0);

    // Reset mid-WAIT, response arrives afterwards and must be ignored.
    doReset("reset5");
    applyStimulus(0, 0, 1, 32'h04, 1, 0, 32'h0, 1);         checkOutput("rst0", 1, 32'h0, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'h04, 1, 0, 32'h0, 1);         checkOutput("rst1", 0, 32'h4, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h08, 0, 1, 32'hCAFE_0000, 1); checkOutput("rst2", 1, 32'h0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h08, 0, 0, 32'h0, 1);         checkOutput("rst3", 1, 32'h0, 0, 0, 0);

    // Randomized traffic against the reference model.
    applyStimulus(1, 0, 1, 32'h0, 0, 0, 32'h0, 0);
    modelStep();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        e_rv, e_idv;
      logic [31:0] e_pc, e_instr;
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) != 0), $urandom() & 32'hFFFF_FFFC,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                    1'($urandom_range(0, 1)));
      e_rv    = !reset && !m_busy && !m_discard && (m_q.size() < 2) && !redirect;
      e_idv   = !reset && (m_q.size() != 0);
      e_pc    = e_idv ? m_q[0].pc : 32'h0;
      e_instr = e_idv ? m_q[0].instr : 32'h0;
      checkOutput($sformatf("rand[%0d]", cyc), e_rv, m_pc, e_idv, e_pc, e_instr);
      modelStep();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
